// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: shares one main-memory port between the instruction cache
// and the data cache. One transaction is in flight at a time. Ties are broken
// in favour of whichever requester was not granted last. A sticky flag records
// any transaction that waits too long for memory.
module segre_mem_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int LINE_SIZE = 128,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 ic_req_i,
  input  logic [ADDR_SIZE-1:0] ic_addr_i,
  input  logic                 dc_req_i,
  input  logic                 dc_we_i,
  input  logic [ADDR_SIZE-1:0] dc_addr_i,
  input  logic [LINE_SIZE-1:0] dc_data_i,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [LINE_SIZE-1:0] mem_data_o,
  input  logic                 mem_ready_i,
  input  logic [LINE_SIZE-1:0] mem_data_i,
  output logic                 ic_ready_o,
  output logic                 dc_ready_o,
  output logic [LINE_SIZE-1:0] rd_data_o,
  output logic                 sel_mem_req_o,
  output logic                 timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IC_BUSY = 2'd1,
    DC_BUSY = 2'd2
  } state_e;

  state_e               state_q, state_d;
  // 1 = DC was granted last, 0 = IC was granted last
  logic                 lastGrant_q, lastGrant_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [LINE_SIZE-1:0] data_q, data_d;
  logic                 we_q, we_d;
  logic [CNT_W-1:0]     waitCnt_q, waitCnt_d;
  logic                 timeout_q, timeout_d;

  logic grantIc;
  logic grantDc;

  // IC wins when it is alone or when DC was served last; otherwise DC wins if asking.
  assign grantIc = ic_req_i && (!dc_req_i || lastGrant_q);
  assign grantDc = dc_req_i && !grantIc;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      waitCnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      waitCnt_q   <= waitCnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic: grant from IDLE, latch the winner's command, count waiting cycles.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = we_q;
    waitCnt_d   = waitCnt_q;

    case (state_q)
      IDLE: begin
        if (grantIc) begin
          state_d     = IC_BUSY;
          lastGrant_d = 1'b0;
          addr_d      = ic_addr_i;
          data_d      = '0;
          we_d        = 1'b0;
          waitCnt_d   = '0;
        end else if (grantDc) begin
          state_d     = DC_BUSY;
          lastGrant_d = 1'b1;
          addr_d      = dc_addr_i;
          data_d      = dc_data_i;
          we_d        = dc_we_i;
          waitCnt_d   = '0;
        end
      end
      IC_BUSY, DC_BUSY: begin
        if (mem_ready_i) begin
          state_d = IDLE;
        end else if (waitCnt_q != CNT_MAX) begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    timeout_d = timeout_q || ((state_q != IDLE) && (waitCnt_d == CNT_MAX));
  end

  // Output decode: commands come from latched registers; ready pulses only while BUSY and out of reset.
  always_comb begin
    mem_rd_o      = 1'b0;
    mem_wr_o      = 1'b0;
    mem_addr_o    = addr_q;
    mem_data_o    = data_q;
    ic_ready_o    = 1'b0;
    dc_ready_o    = 1'b0;
    rd_data_o     = '0;
    sel_mem_req_o = 1'b0;
    timeout_o     = timeout_q;

    case (state_q)
      IC_BUSY: begin
        mem_rd_o = 1'b1;
        if (mem_ready_i && rsn_i) begin
          ic_ready_o = 1'b1;
          rd_data_o  = mem_data_i;
        end
      end
      DC_BUSY: begin
        sel_mem_req_o = 1'b1;
        mem_wr_o      = we_q;
        mem_rd_o      = !we_q;
        if (mem_ready_i && rsn_i) begin
          dc_ready_o = 1'b1;
          rd_data_o  = mem_data_i;
        end
      end
      default: begin
        mem_rd_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb_segre_mem_arbiter: directed stimulus for segre_mem_arbiter. Expected
// transactions are queued as they are issued; a monitor pops one on every ready
// pulse and compares the command, owner, data and command duration.
module tb_segre_mem_arbiter;

  localparam int ADDR_SIZE = 32;
  localparam int LINE_SIZE = 128;
  localparam int TIMEOUT   = 8;

  logic                 clk_i;
  logic                 rsn_i;
  logic                 ic_req_i;
  logic [ADDR_SIZE-1:0] ic_addr_i;
  logic                 dc_req_i;
  logic                 dc_we_i;
  logic [ADDR_SIZE-1:0] dc_addr_i;
  logic [LINE_SIZE-1:0] dc_data_i;
  logic                 mem_rd_o;
  logic                 mem_wr_o;
  logic [ADDR_SIZE-1:0] mem_addr_o;
  logic [LINE_SIZE-1:0] mem_data_o;
  logic                 mem_ready_i;
  logic [LINE_SIZE-1:0] mem_data_i;
  logic                 ic_ready_o;
  logic                 dc_ready_o;
  logic [LINE_SIZE-1:0] rd_data_o;
  logic                 sel_mem_req_o;
  logic                 timeout_o;

  typedef struct {
    logic                 isDc;
    logic [ADDR_SIZE-1:0] addr;
    logic                 rd;
    logic                 wr;
    logic [LINE_SIZE-1:0] wdata;
    logic [LINE_SIZE-1:0] rdata;
    int                   busy;
  } txn_t;

  txn_t sbQ[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [LINE_SIZE-1:0] D1 = {4{32'hC0DE0001}};
  localparam logic [LINE_SIZE-1:0] D2 = {4{32'hC0DE0002}};
  localparam logic [LINE_SIZE-1:0] D3 = {4{32'hC0DE0003}};
  localparam logic [LINE_SIZE-1:0] D4 = {4{32'hC0DE0004}};
  localparam logic [LINE_SIZE-1:0] D5 = {4{32'hC0DE0005}};
  localparam logic [LINE_SIZE-1:0] D6 = {4{32'hC0DE0006}};
  localparam logic [LINE_SIZE-1:0] D7 = {4{32'hC0DE0007}};
  localparam logic [LINE_SIZE-1:0] A5 = {16{8'hA5}};
  localparam logic [LINE_SIZE-1:0] Z  = '0;

  segre_mem_arbiter #(
    .ADDR_SIZE(ADDR_SIZE),
    .LINE_SIZE(LINE_SIZE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i        (clk_i),
    .rsn_i        (rsn_i),
    .ic_req_i     (ic_req_i),
    .ic_addr_i    (ic_addr_i),
    .dc_req_i     (dc_req_i),
    .dc_we_i      (dc_we_i),
    .dc_addr_i    (dc_addr_i),
    .dc_data_i    (dc_data_i),
    .mem_rd_o     (mem_rd_o),
    .mem_wr_o     (mem_wr_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ready_i  (mem_ready_i),
    .mem_data_i   (mem_data_i),
    .ic_ready_o   (ic_ready_o),
    .dc_ready_o   (dc_ready_o),
    .rd_data_o    (rd_data_o),
    .sel_mem_req_o(sel_mem_req_o),
    .timeout_o    (timeout_o)
  );

  // Free-running clock, period 10.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string name, input logic [LINE_SIZE-1:0] actual,
                             input logic [LINE_SIZE-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // One call is one clock cycle: drive just after the rising edge.
  task automatic applyStimulus(input logic icReq, input logic [ADDR_SIZE-1:0] icAddr,
                               input logic dcReq, input logic dcWe,
                               input logic [ADDR_SIZE-1:0] dcAddr,
                               input logic [LINE_SIZE-1:0] dcData,
                               input logic memReady, input logic [LINE_SIZE-1:0] memData);
    @(posedge clk_i);
    #1;
    ic_req_i    = icReq;
    ic_addr_i   = icAddr;
    dc_req_i    = dcReq;
    dc_we_i     = dcWe;
    dc_addr_i   = dcAddr;
    dc_data_i   = dcData;
    mem_ready_i = memReady;
    mem_data_i  = memData;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b0, Z);
  endtask

  task automatic expectTxn(input logic isDc, input logic [ADDR_SIZE-1:0] addr,
                           input logic rd, input logic wr,
                           input logic [LINE_SIZE-1:0] wdata,
                           input logic [LINE_SIZE-1:0] rdata, input int busy);
    txn_t t;
    t.isDc  = isDc;
    t.addr  = addr;
    t.rd    = rd;
    t.wr    = wr;
    t.wdata = wdata;
    t.rdata = rdata;
    t.busy  = busy;
    sbQ.push_back(t);
  endtask

  // Holds reset for two edges and checks that every output is cleared.
  task automatic resetDut();
    idleCycle();
    rsn_i = 1'b0;
    idleCycle();
    @(negedge clk_i);
    checkOutput("rst_mem_rd", 128'(mem_rd_o), 128'(0));
    checkOutput("rst_mem_wr", 128'(mem_wr_o), 128'(0));
    checkOutput("rst_mem_addr", 128'(mem_addr_o), 128'(0));
    checkOutput("rst_mem_data", mem_data_o, Z);
    checkOutput("rst_ic_ready", 128'(ic_ready_o), 128'(0));
    checkOutput("rst_dc_ready", 128'(dc_ready_o), 128'(0));
    checkOutput("rst_rd_data", rd_data_o, Z);
    checkOutput("rst_sel", 128'(sel_mem_req_o), 128'(0));
    checkOutput("rst_timeout", 128'(timeout_o), 128'(0));
    idleCycle();
    rsn_i = 1'b1;
  endtask

  // Monitor: on each ready pulse pop the oldest expected transaction and compare.
  initial begin : monitor
    int   cmdCycles;
    txn_t expT;
    cmdCycles = 0;
    forever begin
      @(negedge clk_i);
      if (!rsn_i) begin
        cmdCycles = 0;
      end else begin
        if (mem_rd_o || mem_wr_o) cmdCycles++;
        if (ic_ready_o || dc_ready_o) begin
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL spurious_ready: actual ic=%b dc=%b required none", ic_ready_o, dc_ready_o);
          end else begin
            expT = sbQ.pop_front();
            checkOutput("sb_ic_ready", 128'(ic_ready_o), 128'(!expT.isDc));
            checkOutput("sb_dc_ready", 128'(dc_ready_o), 128'(expT.isDc));
            checkOutput("sb_mem_addr", 128'(mem_addr_o), 128'(expT.addr));
            checkOutput("sb_mem_rd", 128'(mem_rd_o), 128'(expT.rd));
            checkOutput("sb_mem_wr", 128'(mem_wr_o), 128'(expT.wr));
            checkOutput("sb_sel", 128'(sel_mem_req_o), 128'(expT.isDc));
            if (expT.wr) checkOutput("sb_mem_data", mem_data_o, expT.wdata);
            checkOutput("sb_rd_data", rd_data_o, expT.rdata);
            checkOutput("sb_cmd_cycles", 128'(cmdCycles), 128'(expT.busy));
          end
          cmdCycles = 0;
        end else begin
          checkOutput("rd_data_quiet", rd_data_o, Z);
        end
      end
    end
  end

  // Directed scenario sequence.
  initial begin
    rsn_i       = 1'b0;
    ic_req_i    = 1'b0;
    ic_addr_i   = '0;
    dc_req_i    = 1'b0;
    dc_we_i     = 1'b0;
    dc_addr_i   = '0;
    dc_data_i   = '0;
    mem_ready_i = 1'b0;
    mem_data_i  = '0;

    resetDut();

    // IC line fill, memory answers on the 3rd busy cycle.
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, Z, 1'b0, Z);
    expectTxn(1'b0, 32'h1000, 1'b1, 1'b0, Z, D1, 3);
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, Z, 1'b0, Z);
    @(negedge clk_i);
    checkOutput("t1_first_cmd_rd", 128'(mem_rd_o), 128'(1));
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, Z, 1'b0, Z);
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, Z, 1'b1, D1);
    idleCycle();

    // Simultaneous requests after reset: IC, one idle cycle, DC, then IC again.
    resetDut();
    applyStimulus(1'b1, 32'h2000, 1'b1, 1'b0, 32'h3000, Z, 1'b0, Z);
    expectTxn(1'b0, 32'h2000, 1'b1, 1'b0, Z, D2, 1);
    expectTxn(1'b1, 32'h3000, 1'b1, 1'b0, Z, D3, 2);
    applyStimulus(1'b1, 32'h2000, 1'b1, 1'b0, 32'h3000, Z, 1'b1, D2);
    @(negedge clk_i);
    checkOutput("t2_sel_ic", 128'(sel_mem_req_o), 128'(0));
    applyStimulus(1'b1, 32'h2040, 1'b1, 1'b0, 32'h3000, Z, 1'b0, Z);
    expectTxn(1'b0, 32'h2040, 1'b1, 1'b0, Z, D4, 1);
    @(negedge clk_i);
    checkOutput("t2_gap_rd", 128'(mem_rd_o), 128'(0));
    checkOutput("t2_gap_wr", 128'(mem_wr_o), 128'(0));
    applyStimulus(1'b1, 32'h2040, 1'b1, 1'b0, 32'h3000, Z, 1'b0, Z);
    @(negedge clk_i);
    checkOutput("t2_sel_dc", 128'(sel_mem_req_o), 128'(1));
    applyStimulus(1'b1, 32'h2040, 1'b1, 1'b0, 32'h3000, Z, 1'b1, D3);
    applyStimulus(1'b1, 32'h2040, 1'b0, 1'b0, 32'h0, Z, 1'b0, Z);
    applyStimulus(1'b1, 32'h2040, 1'b0, 1'b0, 32'h0, Z, 1'b1, D4);
    idleCycle();

    // DC write-back; address, data and we change after the grant.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h4000, A5, 1'b0, Z);
    expectTxn(1'b1, 32'h4000, 1'b0, 1'b1, A5, D5, 2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'hDEAD0000, Z, 1'b0, Z);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'hDEAD0000, Z, 1'b1, D5);
    idleCycle();

    // mem_ready_i while IDLE is ignored.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b1, D6);
    @(negedge clk_i);
    checkOutput("t4_ic_ready", 128'(ic_ready_o), 128'(0));
    checkOutput("t4_dc_ready", 128'(dc_ready_o), 128'(0));
    checkOutput("t4_rd_data", rd_data_o, Z);
    idleCycle();
    @(negedge clk_i);
    checkOutput("t4_still_idle_rd", 128'(mem_rd_o), 128'(0));
    checkOutput("t4_still_idle_wr", 128'(mem_wr_o), 128'(0));
    checkOutput("t4_no_timeout", 128'(timeout_o), 128'(0));

    // DC fill that waits past TIMEOUT, then completes.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h5000, Z, 1'b0, Z);
    expectTxn(1'b1, 32'h5000, 1'b1, 1'b0, Z, D7, TIMEOUT + 3);
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h5000, Z, 1'b0, Z);
      @(negedge clk_i);
      if (k == TIMEOUT) checkOutput("t5_timeout_not_yet", 128'(timeout_o), 128'(0));
      if (k == TIMEOUT + 1) checkOutput("t5_timeout_set", 128'(timeout_o), 128'(1));
      if (k == TIMEOUT + 2) checkOutput("t5_timeout_held", 128'(timeout_o), 128'(1));
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h5000, Z, 1'b1, D7);
    idleCycle();
    @(negedge clk_i);
    checkOutput("t5_timeout_sticky", 128'(timeout_o), 128'(1));

    // Reset during IC_BUSY aborts the fill.
    applyStimulus(1'b1, 32'h6000, 1'b0, 1'b0, 32'h0, Z, 1'b0, Z);
    applyStimulus(1'b1, 32'h6000, 1'b0, 1'b0, 32'h0, Z, 1'b0, Z);
    @(negedge clk_i);
    checkOutput("t6_busy_rd", 128'(mem_rd_o), 128'(1));
    applyStimulus(1'b1, 32'h6000, 1'b0, 1'b0, 32'h0, Z, 1'b0, Z);
    rsn_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b1, D6);
    rsn_i = 1'b1;
    @(negedge clk_i);
    checkOutput("t6_abort_rd", 128'(mem_rd_o), 128'(0));
    checkOutput("t6_abort_ic_ready", 128'(ic_ready_o), 128'(0));
    checkOutput("t6_abort_timeout", 128'(timeout_o), 128'(0));
    checkOutput("t6_abort_addr", 128'(mem_addr_o), 128'(0));
    idleCycle();
    idleCycle();

    checkOutput("sb_drain", 128'(sbQ.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
